prg_inject: RTL and testbench
=============================

PRG_INJECT -- requirements
Module: prg_inject

Interface
REQ-001 Parameter AW, default 16: width of target RAM address and of the load-address counter.
REQ-002 Parameter PTR_CNT, default 4, legal 0..4: number of end-pointer pairs patched after load. The fixed table is 0x002D, 0x002F, 0x0031, 0x00AE; the first PTR_CNT entries are used.
REQ-003 Parameter FILE_INDEX, default 1: ioctl_index value that selects this block.
REQ-004 clk_sys  in  1  single clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ioctl_download  in  1  download session active.
REQ-007 ioctl_index  in  8  file-type index.
REQ-008 ioctl_wr  in  1  one-cycle strobe that ioctl_dout is valid.
REQ-009 ioctl_dout  in  8  downloaded byte.
REQ-010 ioctl_wait  out  1  high requests the source to stall strobes.
REQ-011 mem_addr  out  AW  RAM write address.
REQ-012 mem_data  out  8  RAM write data.
REQ-013 mem_wr  out  1  write request, held until acknowledged.
REQ-014 mem_ack  in  1  one-cycle acceptance of the current write.
REQ-015 busy  out  1  session or patch in progress.
REQ-016 done  out  1  one-cycle pulse when the patch phase completes.
REQ-017 err  out  1  sticky: short file or address overflow; cleared at the next session start.

Function
REQ-018 States are IDLE, HDR_LO, HDR_HI, DATA, PATCH, DONE.
REQ-019 IDLE -> HDR_LO on a rising edge of ioctl_download while ioctl_index==FILE_INDEX. The same transition clears err.
REQ-020 HDR_LO: the first accepted byte loads load_addr[7:0]; next state is HDR_HI.
REQ-021 HDR_HI: the second accepted byte loads load_addr[AW-1:8], with AW-8 bits taken from the byte; next state is DATA.
REQ-022 In DATA, each accepted byte is pushed into a 2-entry FIFO.
REQ-023 The FIFO head is issued as mem_addr=cur_addr, mem_data=byte, mem_wr=1.
REQ-024 On mem_ack the FIFO pops and cur_addr increments.
REQ-025 mem_wr and mem_addr/mem_data are stable from assertion until mem_ack.
REQ-026 A new request may issue in the cycle after mem_ack.
REQ-027 ioctl_wait is high whenever the FIFO holds 2 entries.
REQ-028 An ioctl_wr arriving while the FIFO is full is dropped and sets err.
REQ-029 A simultaneous push and pop while the FIFO is full is legal and loses no data.
REQ-030 If cur_addr reaches all-ones and is written, further data bytes are discarded, err is set, and end_addr saturates at all-ones.
REQ-031 On a falling edge of ioctl_download in DATA, the FIFO drains and the block enters PATCH.
REQ-032 On a falling edge in HDR_LO or HDR_HI, err is set and the block returns to IDLE with no writes.
REQ-033 PATCH writes the end address for each table entry i < PTR_CNT, in table order, with the same handshake.
REQ-034 For each entry, end_addr[7:0] goes to the entry address, then end_addr[15:8] to the entry address+1.
REQ-035 end_addr is cur_addr after the last data write, i.e. the last written address + 1.
REQ-036 With PTR_CNT=0, PATCH is skipped.
REQ-037 DONE pulses done for 1 cycle, then the block returns to IDLE.
REQ-038 busy is high in every state except IDLE.
REQ-039 A rising ioctl_download during PATCH is ignored until IDLE.
REQ-040 ioctl_wr with ioctl_index != FILE_INDEX is ignored in all states.

Reset
REQ-041 reset_n low forces: IDLE, FIFO empty, mem_wr=0, ioctl_wait=0, busy=0, done=0, err=0, mem_addr=0, mem_data=0, load_addr=0, cur_addr=0.
REQ-042 Reset mid-session aborts with no further writes.
REQ-043 After reset, a session starts only on a new rising edge of ioctl_download.

Configuration
REQ-044 The macro PRG_INJECT_AUTORUN_EN, when defined, adds an AUTORUN phase after PATCH.
REQ-045 AUTORUN writes 0x52, 0x55, 0x4E, 0x0D to 0x0527..0x052A, then 0x04 to 0x00EF, then proceeds to DONE.
REQ-046 Without PRG_INJECT_AUTORUN_EN, PATCH proceeds directly to DONE and no AUTORUN logic exists.

Verification
REQ-047 File 01 10 AA BB CC, mem_ack tied high -> writes are 1001=AA, 1002=BB, 1003=CC.
REQ-048 The same run then patches 2D/2F/31/AE=04 and 2E/30/32/AF=10, and done pulses once.
REQ-049 File of 3 bytes with mem_ack delayed 5 cycles -> ioctl_wait asserts after the 2nd queued byte, mem_wr is held stable through the delay, and no byte is lost.
REQ-050 File of 1 byte -> err=1, zero memory writes, return to IDLE.
REQ-051 Load address FFFE with 4 data bytes -> FFFE and FFFF are written, err=1, and the patch writes FF/FF.
REQ-052 reset_n pulsed low mid-DATA -> mem_wr=0 the same cycle, no patch writes, and busy=0.
REQ-053 With PRG_INJECT_AUTORUN_EN defined, a valid load is followed by 0527..052A="RUN\r" and 00EF=04 before done.

Source files
------------

// File: rtl/prg_inject.sv
// prg_inject: captures a downloaded program image (2-byte little-endian load
// address followed by data), writes it into target RAM through a
// request/acknowledge port, then patches the end-of-program pointer pairs.
// Optional feature macro: PRG_INJECT_AUTORUN_EN adds an AUTORUN phase that
// types "RUN\r" into the keyboard buffer and sets its length to 4.
module prg_inject #(
  parameter int AW         = 16,
  parameter int PTR_CNT    = 4,
  parameter int FILE_INDEX = 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_wr,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done,
  output logic          err
);

`ifdef PRG_INJECT_AUTORUN_EN
  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, PATCH, AUTORUN, DONE} state_t;
  localparam state_t POST_PATCH = AUTORUN;
`else
  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, PATCH, DONE} state_t;
  localparam state_t POST_PATCH = DONE;
`endif

  localparam int         PATCH_LAST_I = (PTR_CNT > 0) ? (2 * PTR_CNT - 1) : 0;
  localparam logic [2:0] PATCH_LAST   = PATCH_LAST_I[2:0];

  // Low byte address of each end-pointer pair, in patch order.
  function automatic logic [15:0] ptr_base(input logic [1:0] idx);
    case (idx)
      2'd0:    ptr_base = 16'h002D;
      2'd1:    ptr_base = 16'h002F;
      2'd2:    ptr_base = 16'h0031;
      default: ptr_base = 16'h00AE;
    endcase
  endfunction

`ifdef PRG_INJECT_AUTORUN_EN
  localparam logic [2:0] AUTORUN_LAST = 3'd4;

  function automatic logic [15:0] ar_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    ar_addr = 16'h0527;
      3'd1:    ar_addr = 16'h0528;
      3'd2:    ar_addr = 16'h0529;
      3'd3:    ar_addr = 16'h052A;
      default: ar_addr = 16'h00EF;
    endcase
  endfunction

  function automatic logic [7:0] ar_data(input logic [2:0] idx);
    case (idx)
      3'd0:    ar_data = 8'h52;
      3'd1:    ar_data = 8'h55;
      3'd2:    ar_data = 8'h4E;
      3'd3:    ar_data = 8'h0D;
      default: ar_data = 8'h04;
    endcase
  endfunction
`endif

  state_t          state, state_d;
  logic            dl_q;
  logic [AW-1:0]   load_addr, cur_addr;
  logic            addr_init;
  logic [7:0]      fifo_mem [2];
  logic            rd_ptr, wr_ptr;
  logic [1:0]      count;
  logic            drain, ovf, err_q;
  logic [2:0]      step;
  logic [15:0]     end16;

  logic sel, accept, rise, fall, start;
  logic pop, ovf_hit, push_req, push, drop;

  assign sel      = (ioctl_index == 8'(FILE_INDEX));
  assign accept   = ioctl_wr & sel;
  assign rise     = ioctl_download & ~dl_q;
  assign fall     = ~ioctl_download & dl_q;
  assign start    = (state == IDLE) & rise & sel;
  assign pop      = (state == DATA) & (count != 2'd0) & mem_ack;
  assign ovf_hit  = pop & (&cur_addr);
  assign push_req = (state == DATA) & accept & ~drain & ~ovf;
  assign push     = push_req & ~ovf_hit & ((count != 2'd2) | pop);
  assign drop     = push_req & ~ovf_hit & (count == 2'd2) & ~pop;

  assign ioctl_wait = (count == 2'd2);
  assign busy       = (state != IDLE);
  assign err        = err_q;

  // The pointer patch always writes a 16-bit end address.
  if (AW >= 16) begin : g_end_wide
    assign end16 = cur_addr[15:0];
  end else begin : g_end_narrow
    assign end16 = {{(16-AW){1'b0}}, cur_addr};
  end

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state decode and the RAM write port driven from the current phase.
  always_comb begin
    state_d  = state;
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_d = HDR_LO;
      HDR_LO: begin
        if (fall)        state_d = IDLE;
        else if (accept) state_d = HDR_HI;
      end
      HDR_HI: begin
        if (fall)        state_d = IDLE;
        else if (accept) state_d = DATA;
      end
      DATA: begin
        mem_wr   = (count != 2'd0);
        mem_addr = cur_addr;
        mem_data = fifo_mem[rd_ptr];
        if (drain && count == 2'd0) state_d = (PTR_CNT == 0) ? POST_PATCH : PATCH;
      end
      PATCH: begin
        mem_wr   = 1'b1;
        mem_addr = AW'(ptr_base(step[2:1]) + {15'd0, step[0]});
        mem_data = step[0] ? end16[15:8] : end16[7:0];
        if (mem_ack && step == PATCH_LAST) state_d = POST_PATCH;
      end
`ifdef PRG_INJECT_AUTORUN_EN
      AUTORUN: begin
        mem_wr   = 1'b1;
        mem_addr = AW'(ar_addr(step));
        mem_data = ar_data(step);
        if (mem_ack && step == AUTORUN_LAST) state_d = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Header capture, byte FIFO, address counter, phase step and sticky error.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q        <= 1'b1;
      load_addr   <= '0;
      cur_addr    <= '0;
      addr_init   <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
      drain       <= 1'b0;
      ovf         <= 1'b0;
      err_q       <= 1'b0;
      step        <= '0;
    end else begin
      dl_q <= ioctl_download;

      if (start) begin
        err_q     <= 1'b0;
        ovf       <= 1'b0;
        drain     <= 1'b0;
        addr_init <= 1'b0;
        count     <= '0;
        rd_ptr    <= 1'b0;
        wr_ptr    <= 1'b0;
        step      <= '0;
      end

      if ((state == HDR_LO || state == HDR_HI) && fall) err_q <= 1'b1;
      if (state == HDR_LO && !fall && accept) load_addr[7:0] <= ioctl_dout;
      if (state == HDR_HI && !fall && accept) load_addr[AW-1:8] <= ioctl_dout[AW-9:0];

      if (state == DATA && !addr_init) begin
        cur_addr  <= load_addr;
        addr_init <= 1'b1;
      end

      if (state == DATA && fall) drain <= 1'b1;
      if (drop) err_q <= 1'b1;

      if (ovf_hit) begin
        ovf    <= 1'b1;
        err_q  <= 1'b1;
        count  <= '0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          fifo_mem[wr_ptr] <= ioctl_dout;
          wr_ptr           <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr   <= ~rd_ptr;
          cur_addr <= cur_addr + 1'b1;
        end
        if (state == DATA) count <= count + {1'b0, push} - {1'b0, pop};
      end

      if (state == PATCH && mem_ack)
        step <= (step == PATCH_LAST) ? 3'd0 : step + 3'd1;
`ifdef PRG_INJECT_AUTORUN_EN
      if (state == AUTORUN && mem_ack)
        step <= (step == AUTORUN_LAST) ? 3'd0 : step + 3'd1;
`endif
    end
  end

endmodule

// File: tb/tb_prg_inject.sv
// tb_prg_inject: directed checks of prg_inject with hand-computed RAM writes.
module tb_prg_inject;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

`ifdef PRG_INJECT_AUTORUN_EN
  localparam int AR_N = 5;
`else
  localparam int AR_N = 0;
`endif

  logic [15:0] log_addr [$];
  logic [7:0]  log_data [$];
  logic [15:0] ptab [4] = '{16'h002D, 16'h002F, 16'h0031, 16'h00AE};

  bit          ack_mode = 1'b0;
  int          dcnt = 0;
  int          stab_viol = 0;
  logic        held = 1'b0;
  logic [15:0] h_addr = '0;
  logic [7:0]  h_data = '0;

  always #5 clk_sys = ~clk_sys;

  prg_inject #(.AW(16), .PTR_CNT(4), .FILE_INDEX(1)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_wr         (mem_wr),
    .mem_ack        (mem_ack),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  // Record accepted writes and watch that a pending request stays put.
  always @(posedge clk_sys) begin
    if (reset_n && mem_wr && mem_ack) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_data);
    end
    if (reset_n && held && (!mem_wr || mem_addr !== h_addr || mem_data !== h_data))
      stab_viol++;
    held   = reset_n && mem_wr && !mem_ack;
    h_addr = mem_addr;
    h_data = mem_data;
  end

  // Slow RAM: acknowledge a request only after it has waited five cycles.
  always @(negedge clk_sys) begin
    if (ack_mode) begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        dcnt    = 0;
      end else if (mem_wr) begin
        dcnt++;
        if (dcnt > 5) mem_ack = 1'b1;
      end
    end else begin
      dcnt = 0;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input int idx, input logic [15:0] ea, input logic [7:0] ed);
    logic [23:0] obs;
    obs = (idx < log_addr.size()) ? {log_addr[idx], log_data[idx]} : 24'hxxxxxx;
    check_output(tag, {8'd0, obs}, {8'd0, ea, ed});
  endtask

  task automatic check_patch(input int first, input logic [7:0] lo, input logic [7:0] hi);
    for (int i = 0; i < 4; i++) begin
      check_log("patch_lo", first + 2*i,     ptab[i],          lo);
      check_log("patch_hi", first + 2*i + 1, ptab[i] + 16'd1, hi);
    end
  endtask

  task automatic check_autorun(input int first);
`ifdef PRG_INJECT_AUTORUN_EN
    check_log("autorun_r",  first,     16'h0527, 8'h52);
    check_log("autorun_u",  first + 1, 16'h0528, 8'h55);
    check_log("autorun_n",  first + 2, 16'h0529, 8'h4E);
    check_log("autorun_cr", first + 3, 16'h052A, 8'h0D);
    check_log("autorun_len", first + 4, 16'h00EF, 8'h04);
`else
    check_output("autorun_none", log_addr.size(), first);
`endif
  endtask

  // One strobe per cycle, holding off while the block requests a stall.
  task automatic apply_stimulus(input logic [7:0] b);
    int guard = 0;
    while (ioctl_wait && guard < 200) begin
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 200) check_output("wait_bound", {31'd0, ioctl_wait}, 32'd0);
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic run_until_done(input int limit, output int pulses);
    pulses = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_sys);
      if (done) pulses++;
    end
  endtask

  initial begin
    int pulses;
    $display("[TB] start");
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd1;
    ioctl_wr       = 1'b0;
    ioctl_dout     = 8'h00;
    mem_ack        = 1'b1;
    repeat (3) @(negedge clk_sys);

    check_output("rst_wait",  {31'd0, ioctl_wait}, 32'd0);
    check_output("rst_mem_wr", {31'd0, mem_wr},    32'd0);
    check_output("rst_addr",  {16'd0, mem_addr},  32'd0);
    check_output("rst_data",  {24'd0, mem_data},  32'd0);
    check_output("rst_busy",  {31'd0, busy},      32'd0);
    check_output("rst_done",  {31'd0, done},      32'd0);
    check_output("rst_err",   {31'd0, err},       32'd0);

    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Basic load at 0x1001 with a foreign-index strobe in the middle.
    $display("[TB] basic load");
    log_addr.delete(); log_data.delete();
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    check_output("busy_start", {31'd0, busy}, 32'd1);
    apply_stimulus(8'h01);
    apply_stimulus(8'h10);
    apply_stimulus(8'hAA);
    ioctl_index = 8'd2;
    apply_stimulus(8'hEE);
    ioctl_index = 8'd1;
    apply_stimulus(8'hBB);
    apply_stimulus(8'hCC);
    ioctl_download = 1'b0;
    run_until_done(60, pulses);
    check_output("a_done_pulses", pulses, 32'd1);
    check_output("a_busy_end", {31'd0, busy}, 32'd0);
    check_output("a_err", {31'd0, err}, 32'd0);
    check_output("a_nwrites", log_addr.size(), 32'(11 + AR_N));
    check_log("a_w0", 0, 16'h1001, 8'hAA);
    check_log("a_w1", 1, 16'h1002, 8'hBB);
    check_log("a_w2", 2, 16'h1003, 8'hCC);
    check_patch(3, 8'h04, 8'h10);
    check_autorun(11);

    // Slow RAM: the FIFO fills, the source is stalled, nothing is lost.
    $display("[TB] slow ack");
    log_addr.delete(); log_data.delete();
    mem_ack  = 1'b0;
    ack_mode = 1'b1;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    apply_stimulus(8'h00);
    apply_stimulus(8'h20);
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    check_output("b_wait_full", {31'd0, ioctl_wait}, 32'd1);
    check_output("b_mem_wr",    {31'd0, mem_wr},     32'd1);
    check_output("b_addr",      {16'd0, mem_addr},   32'h2000);
    check_output("b_data",      {24'd0, mem_data},   32'h11);
    apply_stimulus(8'h33);
    ioctl_download = 1'b0;
    run_until_done(300, pulses);
    check_output("b_done_pulses", pulses, 32'd1);
    check_output("b_err", {31'd0, err}, 32'd0);
    check_output("b_stable", stab_viol, 32'd0);
    check_output("b_nwrites", log_addr.size(), 32'(11 + AR_N));
    check_log("b_w0", 0, 16'h2000, 8'h11);
    check_log("b_w1", 1, 16'h2001, 8'h22);
    check_log("b_w2", 2, 16'h2002, 8'h33);
    check_patch(3, 8'h03, 8'h20);
    check_autorun(11);
    ack_mode = 1'b0;
    mem_ack  = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Short file: a single header byte.
    $display("[TB] short file");
    log_addr.delete(); log_data.delete();
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    apply_stimulus(8'h01);
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_output("c_err", {31'd0, err}, 32'd1);
    check_output("c_busy", {31'd0, busy}, 32'd0);
    check_output("c_nwrites", log_addr.size(), 32'd0);

    // Address overflow at the top of memory.
    $display("[TB] overflow");
    log_addr.delete(); log_data.delete();
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    check_output("d_err_cleared", {31'd0, err}, 32'd0);
    apply_stimulus(8'hFE);
    apply_stimulus(8'hFF);
    apply_stimulus(8'h01);
    apply_stimulus(8'h02);
    apply_stimulus(8'h03);
    apply_stimulus(8'h04);
    ioctl_download = 1'b0;
    run_until_done(60, pulses);
    check_output("d_done_pulses", pulses, 32'd1);
    check_output("d_err", {31'd0, err}, 32'd1);
    check_output("d_nwrites", log_addr.size(), 32'(10 + AR_N));
    check_log("d_w0", 0, 16'hFFFE, 8'h01);
    check_log("d_w1", 1, 16'hFFFF, 8'h02);
    check_patch(2, 8'hFF, 8'hFF);
    check_autorun(10);

    // Reset while a data write is pending.
    $display("[TB] reset mid-data");
    log_addr.delete(); log_data.delete();
    mem_ack  = 1'b0;
    ack_mode = 1'b1;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    apply_stimulus(8'h00);
    apply_stimulus(8'h30);
    apply_stimulus(8'h55);
    check_output("e_pending", {31'd0, mem_wr}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("e_rst_mem_wr", {31'd0, mem_wr},   32'd0);
    check_output("e_rst_busy",   {31'd0, busy},     32'd0);
    check_output("e_rst_addr",   {16'd0, mem_addr}, 32'd0);
    ack_mode = 1'b0;
    mem_ack  = 1'b1;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);
    check_output("e_no_restart", {31'd0, busy}, 32'd0);
    check_output("e_nwrites", log_addr.size(), 32'd0);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
